// File: rtl/av_mem_arbiter.sv
// Two-master Avalon-MM arbiter in front of a single-port, 1-cycle-read memory; grant is same-cycle, the loser sees WaitRequest.
// Read data returns one cycle after grant. Define MEM_ARB_ROUND_ROBIN_EN for alternating conflict grants (default: AV1 wins).
module av_mem_arbiter #(
  parameter int ADDR_SEL_BITS = 6,
  localparam int AW = 30 - ADDR_SEL_BITS
) (
  input  logic          i_Clk,
  input  logic          i_Rst_n,
  input  logic          i_AV0_SlaveSel,
  input  logic [AW-1:0] i_AV0_RegAddr,
  input  logic          i_AV0_Read,
  output logic [31:0]   o_AV0_ReadData,
  output logic          o_AV0_WaitRequest,
  input  logic          i_AV1_SlaveSel,
  input  logic [AW-1:0] i_AV1_RegAddr,
  input  logic          i_AV1_Read,
  input  logic          i_AV1_Write,
  input  logic [31:0]   i_AV1_WriteData,
  input  logic [3:0]    i_AV1_ByteEnable,
  output logic [31:0]   o_AV1_ReadData,
  output logic          o_AV1_WaitRequest,
  output logic [AW-1:0] o_Mem_Addr,
  output logic          o_Mem_Read,
  output logic          o_Mem_Write,
  output logic [31:0]   o_Mem_WriteData,
  output logic [3:0]    o_Mem_ByteEnable,
  input  logic [31:0]   i_Mem_ReadData
);

  logic       last_gnt_q, last_gnt_d;
  logic [1:0] rd_owner_q, rd_owner_d;
  logic       req0, req1, pick1, gnt0, gnt1;

  always_comb begin
    req0 = i_AV0_SlaveSel & i_AV0_Read;
    req1 = i_AV1_SlaveSel & (i_AV1_Read | i_AV1_Write);
`ifdef MEM_ARB_ROUND_ROBIN_EN
    pick1 = ~last_gnt_q;
`else
    pick1 = 1'b1;
`endif
    // Reset gates the grant so nothing reaches the memory while i_Rst_n is low.
    gnt0 = i_Rst_n & req0 & (~req1 | ~pick1);
    gnt1 = i_Rst_n & req1 & (~req0 | pick1);

    o_AV0_WaitRequest = ~i_Rst_n | (req0 & ~gnt0);
    o_AV1_WaitRequest = ~i_Rst_n | (req1 & ~gnt1);

    o_Mem_Addr       = '0;
    o_Mem_Read       = 1'b0;
    o_Mem_Write      = 1'b0;
    o_Mem_WriteData  = 32'h0;
    o_Mem_ByteEnable = 4'h0;
    if (gnt0) begin
      o_Mem_Addr       = i_AV0_RegAddr;
      o_Mem_Read       = 1'b1;
      o_Mem_ByteEnable = 4'hF;
    end else if (gnt1) begin
      o_Mem_Addr       = i_AV1_RegAddr;
      o_Mem_Write      = i_AV1_Write;
      o_Mem_Read       = i_AV1_Read & ~i_AV1_Write;
      o_Mem_WriteData  = i_AV1_WriteData;
      o_Mem_ByteEnable = i_AV1_ByteEnable;
    end

    last_gnt_d = last_gnt_q;
    if (gnt0)      last_gnt_d = 1'b0;
    else if (gnt1) last_gnt_d = 1'b1;

    rd_owner_d = {gnt1 & i_AV1_Read & ~i_AV1_Write, gnt0};

    o_AV0_ReadData = rd_owner_q[0] ? i_Mem_ReadData : 32'h0;
    o_AV1_ReadData = rd_owner_q[1] ? i_Mem_ReadData : 32'h0;
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      last_gnt_q <= 1'b1;
      rd_owner_q <= 2'b00;
    end else begin
      last_gnt_q <= last_gnt_d;
      rd_owner_q <= rd_owner_d;
    end
  end

endmodule
